// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter for a shared multi-driver bus net.
// Grants at most one requester at a time. A programmable idle turnaround
// separates two ownerships, and an optional hold limit forces release.
// grant/owner/bus_oe/timeout are all registered; busy is decoded from state.
module tristate_bus_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int TURNAROUND = 1,
    parameter int MAX_HOLD   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       bus_oe,
    output logic                       busy,
    output logic                       timeout
);

    localparam int OW = $clog2(NUM_REQ);
    // The hold counter only has to reach MAX_HOLD-1; it saturates beyond that.
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;
    localparam logic [3:0]    TURN_LAST = (TURNAROUND > 0) ? 4'(TURNAROUND - 1) : 4'd0;
    localparam logic [OW-1:0] LAST_IDX  = OW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    state_t             state_reg;
    logic [NUM_REQ-1:0] grant_reg;
    logic [OW-1:0]      owner_reg;
    logic               bus_oe_reg;
    logic               timeout_reg;
    logic [OW-1:0]      rr_ptr_reg;
    logic [HW-1:0]      hold_cnt_reg;
    logic [3:0]         turn_cnt_reg;

    logic               win_valid;
    logic [OW-1:0]      win_idx;
    logic [OW-1:0]      rr_ptr_next;
    logic [NUM_REQ-1:0] win_onehot;
    logic               owner_req;
    logic               hold_limit;

    // Pick the first requester at or above rr_ptr, wrapping; scanning offsets
    // downward lets the smallest offset overwrite the others.
    always_comb begin
        int idx;
        idx       = 0;
        win_valid = 1'b0;
        win_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_reg) + k) % NUM_REQ;
            if (req[idx]) begin
                win_valid = 1'b1;
                win_idx   = OW'(idx);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign win_onehot[gi] = (win_idx == OW'(gi));
        end
    endgenerate

    assign rr_ptr_next = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
    assign owner_req   = req[owner_reg];
    assign hold_limit  = (MAX_HOLD != 0) && (hold_cnt_reg == HOLD_LAST);

    // Arbitration FSM with registered grant, owner, bus enable and timeout pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            grant_reg    <= '0;
            owner_reg    <= '0;
            bus_oe_reg   <= 1'b0;
            timeout_reg  <= 1'b0;
            rr_ptr_reg   <= '0;
            hold_cnt_reg <= '0;
            turn_cnt_reg <= '0;
        end else begin
            timeout_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (win_valid) begin
                        grant_reg    <= win_onehot;
                        owner_reg    <= win_idx;
                        bus_oe_reg   <= 1'b1;
                        hold_cnt_reg <= '0;
                        rr_ptr_reg   <= rr_ptr_next;
                        state_reg    <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (hold_cnt_reg != '1) begin
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    end
                    if (!owner_req || hold_limit) begin
                        grant_reg   <= '0;
                        bus_oe_reg  <= 1'b0;
                        // A voluntary drop coinciding with the limit is a normal release.
                        timeout_reg <= owner_req && hold_limit;
                        if (TURNAROUND > 0) begin
                            state_reg    <= S_TURN;
                            turn_cnt_reg <= '0;
                        end else begin
                            state_reg <= S_IDLE;
                        end
                    end
                end
                S_TURN: begin
                    if (turn_cnt_reg == TURN_LAST) begin
                        state_reg <= S_IDLE;
                    end else begin
                        turn_cnt_reg <= turn_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg  <= S_IDLE;
                    grant_reg  <= '0;
                    bus_oe_reg <= 1'b0;
                end
            endcase
        end
    end

    assign grant   = grant_reg;
    assign owner   = owner_reg;
    assign bus_oe  = bus_oe_reg;
    assign timeout = timeout_reg;
    assign busy    = (state_reg != S_IDLE);

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for tristate_bus_arbiter (NUM_REQ=4, TURNAROUND=1, MAX_HOLD=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_tristate_bus_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       bus_oe;
    logic       busy;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    tristate_bus_arbiter #(
        .NUM_REQ   (4),
        .TURNAROUND(1),
        .MAX_HOLD  (8)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .grant  (grant),
        .owner  (owner),
        .bus_oe (bus_oe),
        .busy   (busy),
        .timeout(timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full output snapshot: grant, owner, bus_oe, busy, timeout.
    task automatic check_all(input string tag, input logic [3:0] g, input logic [1:0] o,
                             input logic b, input logic t);
        $display("step %s: req=%b grant=%b owner=%0d bus_oe=%b busy=%b timeout=%b",
                 tag, req, grant, owner, bus_oe, busy, timeout);
        check({tag, ".grant"}, 32'(grant), 32'(g));
        check({tag, ".owner"}, 32'(owner), 32'(o));
        check({tag, ".bus_oe"}, 32'(bus_oe), 32'(g != 4'b0000));
        check({tag, ".busy"}, 32'(busy), 32'(b));
        check({tag, ".timeout"}, 32'(timeout), 32'(t));
    endtask

    task automatic nclk();
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] cur;
        rst_n = 1'b0;
        req   = 4'b0000;
        nclk();
        nclk();
        check_all("in_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Idle with no requests.
        for (int i = 0; i < 5; i++) begin
            nclk();
            check_all("idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        end

        // Basic grant to requester 2; requester 0 also starts requesting.
        req = 4'b0100;
        nclk();
        check_all("grant2_c1", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b0101;
        nclk();
        check_all("grant2_c2", 4'b0100, 2'd2, 1'b1, 1'b0);
        nclk();
        check_all("grant2_c3", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b0001;
        nclk();
        check_all("release_turn", 4'b0000, 2'd2, 1'b1, 1'b0);
        nclk();
        check_all("release_idle", 4'b0000, 2'd2, 1'b0, 1'b0);
        nclk();
        check_all("grant0", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Round robin with all four requesting; each owner drops for one cycle.
        cur = 4'b0001;
        req = 4'b1111;
        for (int k = 1; k <= 4; k++) begin
            req = 4'b1111 & ~cur;
            nclk();
            check_all("rr_gap_a", 4'b0000, 2'((k + 3) % 4), 1'b1, 1'b0);
            req = 4'b1111;
            nclk();
            check_all("rr_gap_b", 4'b0000, 2'((k + 3) % 4), 1'b0, 1'b0);
            nclk();
            cur = 4'b0001 << (k % 4);
            check_all("rr_grant", cur, 2'(k % 4), 1'b1, 1'b0);
        end

        // Hold limit: requester 1 alone, held continuously.
        req = 4'b0010;
        nclk();
        check_all("hl_gap_a", 4'b0000, 2'd0, 1'b1, 1'b0);
        nclk();
        check_all("hl_gap_b", 4'b0000, 2'd0, 1'b0, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            nclk();
            check_all("hl_own1", 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        nclk();
        check_all("hl_timeout1", 4'b0000, 2'd1, 1'b1, 1'b1);
        nclk();
        check_all("hl_idle1", 4'b0000, 2'd1, 1'b0, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            nclk();
            check_all("hl_own2", 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        nclk();
        check_all("hl_timeout2", 4'b0000, 2'd1, 1'b1, 1'b1);
        nclk();
        check_all("hl_idle2", 4'b0000, 2'd1, 1'b0, 1'b0);

        // Drop on the 8th granted cycle: normal release, no timeout.
        for (int c = 1; c <= 8; c++) begin
            nclk();
            check_all("sd_own", 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        req = 4'b0000;
        nclk();
        check_all("sd_turn", 4'b0000, 2'd1, 1'b1, 1'b0);
        nclk();
        check_all("sd_idle", 4'b0000, 2'd1, 1'b0, 1'b0);

        // Reset mid-ownership with owner 3 (rr_ptr is 2 here).
        req = 4'b1000;
        nclk();
        check_all("own3", 4'b1000, 2'd3, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        req = 4'b1111;
        nclk();
        check_all("held_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        nclk();
        check_all("post_reset_grant", 4'b0001, 2'd0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
